// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: 2-FF sync + per-bit tick-sampled debounce of 10 switches; define SW_DB_BYPASS_EN to skip debounce counters.
module sw_debounce_sync #(
  parameter int TICK_DIV = 50000,
  parameter int STABLE_TICKS = 10,
  parameter logic [9:0] SW_INIT = 10'b0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [9:0] SW_RAW,
  output logic [9:0] SW,
  output logic [9:0] SW_HISTORY,
  output logic       SW_TICK,
  output logic       SW_CHANGE
);
  localparam int PW = $clog2(TICK_DIV);
  logic [9:0] s1_q, s2_q, sw_q, sw_d, hist_q, hist_d, flip;
  logic [PW-1:0] pc_q, pc_d;
  logic tick, tick_q, chg_q, chg_d;
  always_comb begin
    tick = pc_q == PW'(TICK_DIV - 1);
    pc_d = tick ? '0 : pc_q + 1'b1;
    hist_d = tick ? sw_q : hist_q;
    sw_d = sw_q ^ flip;
    chg_d = |flip;
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      s1_q <= SW_INIT;
      s2_q <= SW_INIT;
      sw_q <= SW_INIT;
      hist_q <= SW_INIT;
      pc_q <= '0;
      tick_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      s1_q <= SW_RAW;
      s2_q <= s1_q;
      sw_q <= sw_d;
      hist_q <= hist_d;
      pc_q <= pc_d;
      tick_q <= tick;
      chg_q <= chg_d;
    end
`ifdef SW_DB_BYPASS_EN
  assign flip = tick ? (s2_q ^ sw_q) : '0;
`else
  localparam int DW = $clog2(STABLE_TICKS + 1);
  logic [DW-1:0] dc_q [10];
  logic [DW-1:0] dc_d [10];
  // Any agreeing sample clears the run, so only STABLE_TICKS consecutive disagreements flip a bit.
  always_comb
    for (int i = 0; i < 10; i++) begin
      flip[i] = tick && (s2_q[i] != sw_q[i]) && (dc_q[i] == DW'(STABLE_TICKS - 1));
      dc_d[i] = !tick ? dc_q[i] : (s2_q[i] == sw_q[i] || flip[i]) ? '0 : dc_q[i] + 1'b1;
    end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N)
      for (int i = 0; i < 10; i++) dc_q[i] <= '0;
    else
      for (int i = 0; i < 10; i++) dc_q[i] <= dc_d[i];
`endif
  assign SW = sw_q;
  assign SW_HISTORY = hist_q;
  assign SW_TICK = tick_q;
  assign SW_CHANGE = chg_q;
endmodule

// File: doc/sw_debounce_sync.md
# sw_debounce_sync

Front-end conditioning stage for the ten slide switches. It synchronises the raw board inputs, debounces each switch independently on a slow sample tick, and presents a clean level vector `SW` plus the previous-tick snapshot `SW_HISTORY`. The switch edge/sequence detector directly downstream consumes both vectors. Any `SW` ≠ `SW_HISTORY` difference is held for one full tick period, so the downstream 10-cycle round-robin scan always observes it.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clock cycles per sample tick (1 ms at 50 MHz). Must be ≥ 10.
- `STABLE_TICKS`, default 10: consecutive ticks a synchronised input must disagree with `SW` before `SW` flips. Must be ≥ 1.
- `SW_INIT`, default 10'b0: reset value of `SW` and `SW_HISTORY`.

Ports:
- `CLK` input 1: single clock. All logic is posedge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `SW_RAW` input 10: raw asynchronous switch pins.
- `SW` output 10: debounced switch levels (registered).
- `SW_HISTORY` output 10: value of `SW` as it stood before the most recent tick (registered).
- `SW_TICK` output 1: one-cycle pulse on every sample tick.
- `SW_CHANGE` output 1: one-cycle pulse, coincident with `SW_TICK`, when at least one `SW` bit flipped on that tick.

## Operation
- **Synchroniser:** 2-FF chain per bit, `SW_RAW` → `s1` → `s2`. Both stages reset to `SW_INIT`.
- **Prescaler:** counter `pc` of width clog2(`TICK_DIV`).
  - When `pc` == `TICK_DIV`-1, `pc` wraps to 0 and `tick` is asserted for that cycle.
  - Otherwise `pc` increments.
  - `SW_TICK` is the registered `tick`.
- **Per-bit debounce**, counter `dc[i]` of width clog2(`STABLE_TICKS`+1). Evaluated only on tick cycles:
  - If `s2[i]` == `SW[i]`, then `dc[i]` ← 0.
  - Else if `dc[i]` == `STABLE_TICKS`-1, then `SW[i]` ← `s2[i]` and `dc[i]` ← 0.
  - Else `dc[i]` ← `dc[i]`+1.
- **Glitch handling:** a glitch shorter than `STABLE_TICKS` consecutive ticks is discarded, because any agreeing sample clears the counter.
- **History:** on every tick, `SW_HISTORY` ← `SW` (its pre-update value), in the same edge as the `SW` update.
  - Consequently `SW` ≠ `SW_HISTORY` from the flip tick until the next tick, which is exactly `TICK_DIV` cycles.
- **`SW_CHANGE`:** asserted in the tick cycle's output register when OR over i of the flip conditions is true.
- Multiple bits may flip on the same tick. `SW_HISTORY` then differs from `SW` in all of those bits simultaneously, and `SW_CHANGE` pulses once.
- Bits are fully independent. Activity on one bit never alters another bit's counter.

## Timing
- **Reset values (asynchronous, immediate):**
  - `SW` = `SW_HISTORY` = `SW_INIT`.
  - `SW_TICK` = 0, `SW_CHANGE` = 0.
  - `pc` = 0, all `dc` = 0, sync stages = `SW_INIT`.
- **First tick after reset release:** `SW_TICK` pulses in the cycle following the `TICK_DIV`-th rising edge.
- **Latency, raw change to `SW`:** 2 cycles (sync) + wait for next tick + (`STABLE_TICKS`-1) further ticks.
  - Minimum: 2 + 1 + (`STABLE_TICKS`-1)·`TICK_DIV` cycles.
  - Maximum: 2 + `STABLE_TICKS`·`TICK_DIV` cycles.
- `SW`, `SW_HISTORY`, `SW_TICK` and `SW_CHANGE` all update on the same clock edge.
- **Prescaler wrap:** `TICK_DIV`-1 → 0 with no skipped or doubled tick.
- **Reset mid-count:** all counters are discarded. A switch that is held, unchanged from `SW_INIT`, never produces a flip.
- **Held switch:** a switch held opposite to `SW_INIT` through reset flips on the `STABLE_TICKS`-th tick after release.

## Configuration
- **`SW_DB_BYPASS_EN` defined:**
  - Debounce counters are not built.
  - `SW` ← `s2` on every tick, so flips are tick-aligned with a latency of one tick.
  - `SW_HISTORY`, `SW_TICK` and `SW_CHANGE` keep the rules above.
  - Intended for fast simulation and for pre-debounced sources.
- **Undefined:** full per-bit debounce as specified.

## Test plan
All scenarios use `TICK_DIV`=16, `STABLE_TICKS`=3, `SW_INIT`=0.
- **Reset:** assert `RESET_N`=0 mid-run → `SW`=`SW_HISTORY`=0, `SW_TICK`=`SW_CHANGE`=0 immediately. After release, the first `SW_TICK` arrives 16 cycles later and then every 16 cycles.
- **Clean press:** `SW_RAW[3]` 0→1 and held → `SW[3]`=1 on the 3rd tick after sync, with one `SW_CHANGE` pulse. `SW_HISTORY[3]` stays 0 for exactly 16 cycles, then becomes 1.
- **Glitch rejection:** `SW_RAW[5]` high for 2 ticks, low for 1 tick, high for 2 ticks → `SW[5]` stays 0 and `SW_CHANGE` never pulses.
- **Simultaneous flips:** `SW_RAW` = 10'h201 applied in one cycle → `SW` = 10'h201 on a single tick, `SW_HISTORY` = 0 for that tick period, one `SW_CHANGE` pulse.
- **Release:** with `SW[3]`=1, drop `SW_RAW[3]` → `SW[3]`=0 after 3 ticks, with `SW_HISTORY[3]`=1 for the following 16 cycles.
- **Bypass (`SW_DB_BYPASS_EN`):** a 1-tick pulse on `SW_RAW[0]` → `SW[0]`=1 for exactly one tick period, with `SW_CHANGE` pulsing on the rise tick and again on the fall tick.
